// File: rtl/substitution_layer_seq_pkg.sv
// Shared ASCON types and S-box tables for the sequential substitution layer.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {IDLE, RUN, DONE} type_subst_fsm;

  localparam logic [4:0] SBOX_C [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam logic [4:0] SBOX_INV_C [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

endpackage

// File: rtl/substitution_layer_seq_sbox5.sv
// 5-bit ASCON S-box lookup; inv selects the inverse table.
module ascon_sbox5
  import ascon_pack::*;
(
  input  logic       inv,
  input  logic [4:0] x,
  output logic [4:0] y
);

  assign y = inv ? SBOX_INV_C[x] : SBOX_C[x];

endmodule

// File: rtl/substitution_layer_seq.sv
// Sequential ASCON p_S: COLS_PER_CYCLE columns substituted per clock, done pulse at the end.
// Optional macro SUBST_LAYER_INV_EN adds inv_i to select the inverse S-box.
module substitution_layer_seq
  import ascon_pack::*;
#(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
`ifdef SUBST_LAYER_INV_EN
  input  logic      inv_i,
`endif
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      done_o
);

  localparam int W         = COLS_PER_CYCLE;
  localparam int NB_CHUNKS = 64 / COLS_PER_CYCLE;
  localparam int CNT_W     = (NB_CHUNKS > 1) ? $clog2(NB_CHUNKS) : 1;

  if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_cols
    $error("substitution_layer_seq: COLS_PER_CYCLE must be a power of two in 1..64");
  end

  type_subst_fsm      fsm_q, fsm_d;
  logic [CNT_W-1:0]   cnt;
  logic               last_chunk;
  logic               inv_sel;
  logic [4:0][W-1:0]  chunk_in;
  logic [4:0][W-1:0]  chunk_out;

`ifdef SUBST_LAYER_INV_EN
  logic inv_q;
  assign inv_sel = inv_q;
`else
  assign inv_sel = 1'b0;
`endif

  assign last_chunk = (cnt == CNT_W'(NB_CHUNKS - 1));

  // Column mux: rows of the chunk currently addressed by cnt
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      chunk_in[r] = state_o[r][int'(cnt) * W +: W];
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_lane
    logic [4:0] col_x;
    logic [4:0] col_y;
    assign col_x = {chunk_in[0][i], chunk_in[1][i], chunk_in[2][i], chunk_in[3][i], chunk_in[4][i]};
    ascon_sbox5 u_sbox (
      .inv (inv_sel),
      .x   (col_x),
      .y   (col_y)
    );
    assign chunk_out[0][i] = col_y[4];
    assign chunk_out[1][i] = col_y[3];
    assign chunk_out[2][i] = col_y[2];
    assign chunk_out[3][i] = col_y[1];
    assign chunk_out[4][i] = col_y[0];
  end

  always_comb begin
    fsm_d  = fsm_q;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (fsm_q)
      IDLE: if (start_i) fsm_d = RUN;
      RUN: begin
        busy_o = 1'b1;
        if (last_chunk) fsm_d = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Working register: loaded on accept, then rewritten one chunk per edge
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      cnt     <= '0;
      state_o <= '0;
`ifdef SUBST_LAYER_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_o <= state_i;
            cnt     <= '0;
`ifdef SUBST_LAYER_INV_EN
            inv_q   <= inv_i;
`endif
          end
        end
        RUN: begin
          for (int r = 0; r < 5; r++) begin
            state_o[r][int'(cnt) * W +: W] <= chunk_out[r];
          end
          cnt <= last_chunk ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_substitution_layer_seq.sv
// Scoreboard bench for substitution_layer_seq at COLS_PER_CYCLE = 1, 4 and 64.
module tb_substitution_layer_seq;
  import ascon_pack::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  type_state  state_in;
  type_state  st_o [3];
  logic [2:0] busy;
  logic [2:0] done;
`ifdef SUBST_LAYER_INV_EN
  logic [2:0] inv;
`endif

  int checks = 0;
  int errors = 0;
  type_state exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int C = (g == 0) ? 1 : ((g == 1) ? 4 : 64);
    substitution_layer_seq #(.COLS_PER_CYCLE(C)) u_dut (
      .clock_i (clk),
      .reset_i (rst),
      .start_i (start[g]),
`ifdef SUBST_LAYER_INV_EN
      .inv_i   (inv[g]),
`endif
      .state_i (state_in),
      .state_o (st_o[g]),
      .busy_o  (busy[g]),
      .done_o  (done[g])
    );
  end

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic int nb_of(input int k);
    return (k == 0) ? 64 : ((k == 1) ? 16 : 1);
  endfunction

  // Bitsliced ASCON S-box on whole rows, independent of the lookup tables
  function automatic type_state sbox_model(input type_state s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    o[0] = x0; o[1] = x1; o[2] = x2; o[3] = x3; o[4] = x4;
    return o;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int r = 0; r < 5; r++) s[r] = {$urandom(), $urandom()};
    return s;
  endfunction

  // Called at #1 after a rising edge with the DUT idle
  task automatic run_op(input int k, input type_state s, input logic inv_b,
                        input type_state e, input int extra, output type_state res);
    int n;
    int busy_gaps;
    type_state got;
    state_in = s;
    start[k] = 1'b1;
`ifdef SUBST_LAYER_INV_EN
    inv[k] = inv_b;
`endif
    exp_q.push_back(e);
    @(posedge clk); #1;
    start[k] = 1'b0;
    state_in = ~s;
`ifdef SUBST_LAYER_INV_EN
    inv[k] = ~inv_b;
`endif
    chk($sformatf("busy_start_k%0d", k), busy[k], 1'b1);
    n = 0;
    busy_gaps = 0;
    while (!done[k] && n < 200) begin
      if (busy[k] !== 1'b1) busy_gaps++;
      if (n == extra) start[k] = 1'b1;
      @(posedge clk); #1;
      start[k] = 1'b0;
      n++;
    end
    chk($sformatf("latency_k%0d", k), n, nb_of(k));
    chk($sformatf("busy_run_k%0d", k), busy_gaps, 0);
    chk($sformatf("busy_done_k%0d", k), busy[k], 1'b0);
    got = st_o[k];
    if (exp_q.size() == 0) begin
      chk($sformatf("sb_empty_k%0d", k), 0, 1);
      res = got;
    end else begin
      res = exp_q.pop_front();
      chk($sformatf("result_k%0d", k), got, res);
    end
    @(posedge clk); #1;
    chk($sformatf("done_pulse_k%0d", k), done[k], 1'b0);
    chk($sformatf("hold_k%0d", k), st_o[k], res);
  endtask

  task automatic reset_mid(input int k, input type_state s);
    int dn;
    state_in = s;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    for (int i = 0; i < ((nb_of(k) > 2) ? 2 : 0); i++) begin
      @(posedge clk); #1;
    end
    chk($sformatf("busy_pre_rst_k%0d", k), busy[k], 1'b1);
    rst = 1'b1;
    #1;
    chk($sformatf("rst_state_k%0d", k), st_o[k], 320'h0);
    chk($sformatf("rst_busy_k%0d", k), busy[k], 1'b0);
    chk($sformatf("rst_done_k%0d", k), done[k], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < nb_of(k) + 4; i++) begin
      @(posedge clk); #1;
      if (done[k]) dn++;
    end
    chk($sformatf("no_done_after_rst_k%0d", k), dn, 0);
    chk($sformatf("post_rst_state_k%0d", k), st_o[k], 320'h0);
  endtask

  initial begin
    type_state s, e, vec, res, r;
    rst      = 1'b1;
    start    = '0;
    state_in = '0;
`ifdef SUBST_LAYER_INV_EN
    inv      = '0;
`endif
    vec[0] = 64'h80400c0600000000;
    vec[1] = 64'h8a55114d1cb6a9a2;
    vec[2] = 64'hbe263d4d7aecaa0f;
    vec[3] = 64'h4ed0ec0b98c529b7;
    vec[4] = 64'hc8cddf37bcd0284a;

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_state_k%0d", k), st_o[k], 320'h0);
      chk($sformatf("reset_busy_k%0d", k), busy[k], 1'b0);
      chk($sformatf("reset_done_k%0d", k), done[k], 1'b0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) begin
      s = '0; e = '0; e[2] = '1;
      run_op(k, s, 1'b0, e, -1, res);

      s = '1; e = '1; e[1] = '0;
      run_op(k, s, 1'b0, e, -1, res);

      s = '0; s[4] = 64'h1;
      e[0] = 64'h0; e[1] = 64'h1; e[2] = 64'hFFFF_FFFF_FFFF_FFFE; e[3] = 64'h1; e[4] = 64'h1;
      run_op(k, s, 1'b0, e, -1, res);

      run_op(k, vec, 1'b0, sbox_model(vec), -1, res);

      // Second start pulse while busy must be ignored
      run_op(k, vec, 1'b0, sbox_model(vec), (nb_of(k) > 2) ? 2 : 0, res);

      for (int i = 0; i < 2; i++) begin
        r = rand_state();
        run_op(k, r, 1'b0, sbox_model(r), -1, res);
      end

      reset_mid(k, vec);

`ifdef SUBST_LAYER_INV_EN
      run_op(k, vec, 1'b0, sbox_model(vec), -1, res);
      run_op(k, res, 1'b1, vec, -1, res);
      for (int i = 0; i < 2; i++) begin
        r = rand_state();
        run_op(k, r, 1'b0, sbox_model(r), -1, res);
        run_op(k, res, 1'b1, r, -1, res);
      end
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
